vga_rect_fill_ctrl: RTL and testbench

Command-driven pixel sequencer for the 160x120, 3-bit-colour VGA plot port (x, y, colour, plot). It accepts one rectangle-fill or full-screen-clear command through a valid/ready handshake. It then steps the plot port through every covered pixel, one per clock, clipping the rectangle to the screen edges. It sits between demo/game logic and the VGA adapter, so demo/game logic never has to generate pixel scans itself.

---
 rtl/vga_rect_fill_ctrl.sv | 149 ++++++++++++++
 tb/tb_vga_rect_fill_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rect_fill_ctrl.sv
// rtl/vga_rect_fill_ctrl.sv - command-driven rectangle fill / screen clear pixel sequencer
//
// Accepts one fill command over a valid/ready handshake and steps the VGA plot
// port through every covered pixel, one per clock, in row-major order. The
// rectangle is clipped to the visible screen.
//
// Ports:
//   CLOCK_50    system clock, rising edge
//   reset       asynchronous active-high reset
//   cmd_valid   command present
//   cmd_ready   block can accept a command (decoded from state, IDLE only)
//   cmd_x/y     rectangle top-left corner
//   cmd_w/h     rectangle size in pixels
//   cmd_colour  fill colour
//   cmd_clear   fill the whole screen, geometry fields ignored
//   x/y/colour  registered pixel coordinate and colour
//   plot        pixel write strobe, high exactly in FILL cycles
//   busy        high in FILL and DONE
//   done        one-cycle completion pulse
module vga_rect_fill_ctrl #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_x,
    input  logic [6:0] cmd_y,
    input  logic [7:0] cmd_w,
    input  logic [6:0] cmd_h,
    input  logic [2:0] cmd_colour,
    input  logic       cmd_clear,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE
    } state_t;

    localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);
    localparam logic [8:0] X_LIM  = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIM  = 8'(SCREEN_H);

    state_t     state;
    logic [7:0] x0;
    logic [7:0] x_end;
    logic [6:0] y_end;

    // Command decode, evaluated combinationally and captured on acceptance.
    logic [8:0] x_sum;
    logic [7:0] y_sum;
    logic       cmd_empty;
    logic [7:0] new_x0;
    logic [6:0] new_y0;
    logic [7:0] new_x_end;
    logic [6:0] new_y_end;

    always_comb begin
        // Sums are one bit wider than the fields so they cannot wrap.
        x_sum     = {1'b0, cmd_x} + {1'b0, cmd_w};
        y_sum     = {1'b0, cmd_y} + {1'b0, cmd_h};
        new_x0    = cmd_x;
        new_y0    = cmd_y;
        new_x_end = (x_sum > X_LIM) ? X_LAST : (cmd_x + cmd_w - 8'd1);
        new_y_end = (y_sum > Y_LIM) ? Y_LAST : (cmd_y + cmd_h - 7'd1);
        cmd_empty = (cmd_w == 8'd0) || (cmd_h == 7'd0) ||
                    (cmd_x >= X_LIM[7:0]) || ({1'b0, cmd_y} >= Y_LIM);
        if (cmd_clear) begin
            new_x0    = 8'd0;
            new_y0    = 7'd0;
            new_x_end = X_LAST;
            new_y_end = Y_LAST;
            cmd_empty = 1'b0;
        end
    end

    assign cmd_ready = (state == S_IDLE);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            x0     <= 8'd0;
            x_end  <= 8'd0;
            y_end  <= 7'd0;
            x      <= 8'd0;
            y      <= 7'd0;
            colour <= 3'd0;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        busy <= 1'b1;
                        if (cmd_empty) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            // First pixel is presented in the cycle right after acceptance.
                            state  <= S_FILL;
                            x0     <= new_x0;
                            x_end  <= new_x_end;
                            y_end  <= new_y_end;
                            x      <= new_x0;
                            y      <= new_y0;
                            colour <= cmd_colour;
                            plot   <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (x == x_end && y == y_end) begin
                        // Last pixel shown this cycle; x/y keep its coordinate.
                        state <= S_DONE;
                        plot  <= 1'b0;
                        done  <= 1'b1;
                    end else if (x == x_end) begin
                        x <= x0;
                        y <= y + 7'd1;
                    end else begin
                        x <= x + 8'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    plot  <= 1'b0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_rect_fill_ctrl.sv
// tb/tb_vga_rect_fill_ctrl.sv - directed self-checking bench for vga_rect_fill_ctrl
module tb_vga_rect_fill_ctrl;

    logic       CLOCK_50;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_x;
    logic [6:0] cmd_y;
    logic [7:0] cmd_w;
    logic [6:0] cmd_h;
    logic [2:0] cmd_colour;
    logic       cmd_clear;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    vga_rect_fill_ctrl dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_colour(cmd_colour),
        .cmd_clear (cmd_clear),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int n_cmp = 0;
    int n_err = 0;

    int qx[$];
    int qy[$];
    int qc[$];
    int qcyc[$];
    int n_off;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // Issue one command at edge 0, collect plotted pixels until done (bounded),
    // then advance to cycle done+1 so the caller can check cmd_ready.
    task automatic run_cmd(input logic clr, input logic [7:0] cx, input logic [6:0] cy,
                           input logic [7:0] cw, input logic [6:0] ch, input logic [2:0] cc,
                           output int done_cyc);
        qx.delete(); qy.delete(); qc.delete(); qcyc.delete();
        n_off    = 0;
        done_cyc = -1;
        @(negedge CLOCK_50);
        cmd_clear = clr; cmd_x = cx; cmd_y = cy; cmd_w = cw; cmd_h = ch; cmd_colour = cc;
        cmd_valid = 1'b1;
        @(posedge CLOCK_50); #1;
        cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 19300; cyc++) begin
            if (plot) begin
                qx.push_back(int'(x)); qy.push_back(int'(y)); qc.push_back(int'(colour));
                qcyc.push_back(cyc);
                if (x >= 8'd160 || y >= 7'd120) n_off++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge CLOCK_50); #1;
        end
        @(posedge CLOCK_50); #1;
    endtask

    int dc;
    int bad;
    int nplot;
    int exp_x[6];
    int exp_y[6];
    int exp_cy[6];

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_x = 8'd0; cmd_y = 7'd0; cmd_w = 8'd0;
        cmd_h = 7'd0; cmd_colour = 3'd0; cmd_clear = 1'b0;
        #1;
        check("rst_plot", plot, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_xy", {x, 1'b0, y}, 0);
        check("rst_colour", colour, 0);
        @(negedge CLOCK_50); @(negedge CLOCK_50);
        reset = 1'b0;

        // 3x2 rectangle at (10,5), colour 4
        exp_x = '{10, 11, 12, 10, 11, 12};
        exp_y = '{5, 5, 5, 6, 6, 6};
        run_cmd(1'b0, 8'd10, 7'd5, 8'd3, 7'd2, 3'd4, dc);
        check("rect_count", qx.size(), 6);
        if (qx.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("rect_x%0d", i), qx[i], exp_x[i]);
                check($sformatf("rect_y%0d", i), qy[i], exp_y[i]);
                check($sformatf("rect_c%0d", i), qc[i], 4);
                check($sformatf("rect_cyc%0d", i), qcyc[i], i + 1);
            end
        end
        check("rect_done_cyc", dc, 7);
        check("rect_ready_n2", cmd_ready, 1);

        // Clipping at the bottom-right corner
        exp_x = '{158, 159, 158, 159, 0, 0};
        exp_y = '{118, 118, 119, 119, 0, 0};
        run_cmd(1'b0, 8'd158, 7'd118, 8'd5, 7'd5, 3'd2, dc);
        check("clip_count", qx.size(), 4);
        check("clip_offscreen", n_off, 0);
        if (qx.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("clip_x%0d", i), qx[i], exp_x[i]);
                check($sformatf("clip_y%0d", i), qy[i], exp_y[i]);
            end
        end
        check("clip_done_cyc", dc, 5);

        // Empty / off-screen commands
        run_cmd(1'b0, 8'd10, 7'd10, 8'd0, 7'd4, 3'd1, dc);
        check("w0_count", qx.size(), 0);
        check("w0_done_cyc", dc, 1);
        check("w0_ready", cmd_ready, 1);
        run_cmd(1'b0, 8'd200, 7'd10, 8'd4, 7'd4, 3'd1, dc);
        check("x200_count", qx.size(), 0);
        check("x200_done_cyc", dc, 1);
        run_cmd(1'b0, 8'd10, 7'd120, 8'd4, 7'd4, 3'd1, dc);
        check("y120_count", qx.size(), 0);
        check("y120_done_cyc", dc, 1);

        // Full clear with garbage geometry
        run_cmd(1'b1, 8'd250, 7'd127, 8'd3, 7'd0, 3'd0, dc);
        check("clear_count", qx.size(), 19200);
        bad = 0;
        for (int i = 0; i < qx.size(); i++)
            if (qx[i] != i % 160 || qy[i] != i / 160 || qc[i] != 0) bad++;
        check("clear_order_bad", bad, 0);
        check("clear_done_cyc", dc, 19201);
        if (qx.size() > 0) check("clear_last", qx[qx.size()-1] * 1000 + qy[qx.size()-1], 159119);

        // Reset in the middle of a 20x20 fill, at pixel 50
        @(negedge CLOCK_50);
        cmd_clear = 1'b0; cmd_x = 8'd0; cmd_y = 7'd0; cmd_w = 8'd20; cmd_h = 7'd20; cmd_colour = 3'd5;
        cmd_valid = 1'b1;
        @(posedge CLOCK_50); #1;
        cmd_valid = 1'b0;
        nplot = 0;
        for (int cyc = 1; cyc <= 200 && nplot < 50; cyc++) begin
            if (plot) nplot++;
            if (nplot < 50) begin @(posedge CLOCK_50); #1; end
        end
        check("mid_plots_before_rst", nplot, 50);
        reset = 1'b1;
        #1;
        check("mid_rst_plot", plot, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        @(negedge CLOCK_50); @(negedge CLOCK_50);
        reset = 1'b0;
        nplot = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge CLOCK_50); #1;
            if (plot || busy) nplot++;
        end
        check("mid_no_resume", nplot, 0);
        check("mid_ready", cmd_ready, 1);

        // cmd_valid held through completion with changing fields
        exp_x  = '{20, 21, 20, 21, 50, 50};
        exp_y  = '{30, 30, 31, 31, 60, 61};
        exp_cy = '{1, 2, 3, 4, 7, 8};
        qx.delete(); qy.delete(); qc.delete(); qcyc.delete();
        @(negedge CLOCK_50);
        cmd_clear = 1'b0; cmd_x = 8'd20; cmd_y = 7'd30; cmd_w = 8'd2; cmd_h = 7'd2; cmd_colour = 3'd3;
        cmd_valid = 1'b1;
        @(posedge CLOCK_50); #1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            if (plot) begin
                qx.push_back(int'(x)); qy.push_back(int'(y)); qc.push_back(int'(colour));
                qcyc.push_back(cyc);
            end
            if (cyc == 5) begin
                check("hold_done5", done, 1);
                check("hold_busy5", busy, 1);
                check("hold_ready5", cmd_ready, 0);
            end
            if (cyc == 6) begin
                check("hold_ready6", cmd_ready, 1);
                check("hold_busy6", busy, 0);
            end
            if (cyc == 9) check("hold_done9", done, 1);
            if (cyc < 6) begin
                cmd_x = 8'(cyc * 7); cmd_y = 7'(cyc * 3); cmd_w = 8'd5; cmd_h = 7'd5; cmd_colour = 3'd1;
            end else if (cyc == 6) begin
                cmd_x = 8'd50; cmd_y = 7'd60; cmd_w = 8'd1; cmd_h = 7'd2; cmd_colour = 3'd6;
            end else begin
                cmd_valid = 1'b0;
            end
            @(posedge CLOCK_50); #1;
        end
        check("hold_count", qx.size(), 6);
        if (qx.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("hold_x%0d", i), qx[i], exp_x[i]);
                check($sformatf("hold_y%0d", i), qy[i], exp_y[i]);
                check($sformatf("hold_c%0d", i), qc[i], (i < 4) ? 3 : 6);
                check($sformatf("hold_cyc%0d", i), qcyc[i], exp_cy[i]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
